// File: rtl/recwind_monitor.sv
// Passive TCP receive-window monitor: forwards a word stream through a 4-deep FIFO and
// captures window/checksum from IPv4/TCP packets. `RECWIND_MONITOR_ZERO_WIN_EN adds a zero-window counter.
module recwind_monitor #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  stat_clr,
  output logic [15:0]           last_win,
  output logic [15:0]           last_csum,
  output logic [15:0]           min_win,
  output logic [31:0]           tcp_pkt_cnt,
  output logic [31:0]           other_pkt_cnt,
  output logic [31:0]           zero_win_cnt,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    CTRL_HDR  = 3'd0,
    WORD2_ETH = 3'd1,
    WORD3_IP  = 3'd2,
    WAIT_W7   = 3'd3,
    CAPTURE   = 3'd4,
    PASS      = 3'd5
  } state_t;

  // Handshake: a word enters on in_wr while space remains (in_rdy promises >= 2 free slots);
  // a word leaves when the FIFO is non-empty and out_rdy is high, appearing on out_* one cycle later.
  logic [DATA_WIDTH-1:0] data_mem [4];
  logic [CTRL_WIDTH-1:0] ctrl_mem [4];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]            count_q;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic                  head_is_ctrl;

  assign push         = in_wr && (count_q != 3'd4);
  assign pop          = (count_q != 3'd0) && out_rdy;
  assign in_rdy       = (count_q < 3'd3);
  assign head_data    = data_mem[rd_ptr_q];
  assign head_ctrl    = ctrl_mem[rd_ptr_q];
  assign head_is_ctrl = |head_ctrl;

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= in_data;
      ctrl_mem[wr_ptr_q] <= in_ctrl;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CTRL_WIDTH-1:0] out_ctrl_q;
  logic                  out_wr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data_q <= '0;
      out_ctrl_q <= '0;
      out_wr_q   <= 1'b0;
    end else begin
      out_wr_q <= pop;
      if (pop) begin
        out_data_q <= head_data;
        out_ctrl_q <= head_ctrl;
      end
    end
  end

  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;
  assign out_wr   = out_wr_q;

  state_t      state_q;
  logic [2:0]  wcnt_q;
  logic        nonqual_q;
  logic [15:0] last_win_q, last_csum_q, min_win_q;
  logic [31:0] tcp_cnt_q, other_cnt_q;
  logic        cap_ev, other_ev, eth_ok, ip_ok;
  logic [15:0] cap_win, cap_csum;

  assign eth_ok   = (head_data[31:16] == 16'h0800) && (head_data[15:8] == 8'h45);
  assign ip_ok    = (head_data[7:0] == 8'h06);
  assign cap_win  = head_data[63:48];
  assign cap_csum = head_data[47:32];

  // An early EOP on a still-qualifying packet counts as "other", as does the EOP of a rejected one.
  always_comb begin
    cap_ev   = pop && (state_q == CAPTURE) && !head_is_ctrl;
    other_ev = 1'b0;
    if (pop && head_is_ctrl) begin
      case (state_q)
        WORD2_ETH, WORD3_IP, WAIT_W7, CAPTURE: other_ev = 1'b1;
        PASS:                                  other_ev = nonqual_q;
        default:                               other_ev = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CTRL_HDR;
      wcnt_q      <= 3'd0;
      nonqual_q   <= 1'b0;
      last_win_q  <= 16'h0000;
      last_csum_q <= 16'h0000;
      min_win_q   <= 16'hFFFF;
      tcp_cnt_q   <= 32'd0;
      other_cnt_q <= 32'd0;
    end else begin
      if (pop) begin
        case (state_q)
          CTRL_HDR: if (!head_is_ctrl) state_q <= WORD2_ETH;
          WORD2_ETH: begin
            if (head_is_ctrl) state_q <= CTRL_HDR;
            else if (eth_ok)  state_q <= WORD3_IP;
            else begin
              state_q   <= PASS;
              nonqual_q <= 1'b1;
            end
          end
          WORD3_IP: begin
            if (head_is_ctrl) state_q <= CTRL_HDR;
            else if (ip_ok) begin
              state_q <= WAIT_W7;
              wcnt_q  <= 3'd4;
            end else begin
              state_q   <= PASS;
              nonqual_q <= 1'b1;
            end
          end
          WAIT_W7: begin
            if (head_is_ctrl)         state_q <= CTRL_HDR;
            else if (wcnt_q == 3'd6)  state_q <= CAPTURE;
            else                      wcnt_q  <= wcnt_q + 3'd1;
          end
          CAPTURE: begin
            if (head_is_ctrl) state_q <= CTRL_HDR;
            else begin
              state_q   <= PASS;
              nonqual_q <= 1'b0;
            end
          end
          PASS:    if (head_is_ctrl) state_q <= CTRL_HDR;
          default: state_q <= CTRL_HDR;
        endcase
      end
      // A clear in the same cycle as a capture drops that capture entirely.
      if (stat_clr) begin
        min_win_q   <= 16'hFFFF;
        tcp_cnt_q   <= 32'd0;
        other_cnt_q <= 32'd0;
      end else begin
        if (cap_ev) begin
          last_win_q  <= cap_win;
          last_csum_q <= cap_csum;
          tcp_cnt_q   <= tcp_cnt_q + 32'd1;
          if (cap_win < min_win_q) min_win_q <= cap_win;
        end
        if (other_ev) other_cnt_q <= other_cnt_q + 32'd1;
      end
    end
  end

  assign last_win      = last_win_q;
  assign last_csum     = last_csum_q;
  assign min_win       = min_win_q;
  assign tcp_pkt_cnt   = tcp_cnt_q;
  assign other_pkt_cnt = other_cnt_q;
  assign dbg_state     = state_q;

`ifdef RECWIND_MONITOR_ZERO_WIN_EN
  logic [31:0] zero_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           zero_cnt_q <= 32'd0;
    else if (stat_clr)                    zero_cnt_q <= 32'd0;
    else if (cap_ev && cap_win == 16'h0)  zero_cnt_q <= zero_cnt_q + 32'd1;
  end

  assign zero_win_cnt = zero_cnt_q;
`else
  assign zero_win_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_recwind_monitor.sv
// Directed bench for recwind_monitor: packet-level reference model plus per-cycle output compare.
module tb_recwind_monitor;
  localparam int DW = 64;
  localparam int CW = 8;
`ifdef RECWIND_MONITOR_ZERO_WIN_EN
  localparam bit ZW_EN = 1'b1;
`else
  localparam bit ZW_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          in_wr = 1'b0;
  logic          in_rdy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr;
  logic          out_rdy = 1'b0;
  logic          stat_clr = 1'b0;
  logic [15:0]   last_win, last_csum, min_win;
  logic [31:0]   tcp_pkt_cnt, other_pkt_cnt, zero_win_cnt;
  logic [2:0]    dbg_state;

  recwind_monitor #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
    .out_rdy(out_rdy), .stat_clr(stat_clr), .last_win(last_win), .last_csum(last_csum),
    .min_win(min_win), .tcp_pkt_cnt(tcp_pkt_cnt), .other_pkt_cnt(other_pkt_cnt),
    .zero_win_cnt(zero_win_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [DW+CW-1:0] exp_q[$];
  logic [DW-1:0] pkt_d[$];
  logic [CW-1:0] pkt_c[$];
  int rdy_mode = 0;
  logic clr_edge = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet-level view of the output stream.
  logic [15:0] m_last_win = 0, m_last_csum = 0, m_min = 16'hFFFF;
  logic [31:0] m_tcp = 0, m_other = 0, m_zero = 0;
  bit          m_in_pkt = 0, m_captured = 0;
  logic [DW-1:0] m_data[$];
  bit          ev_cap, ev_other;
  logic [15:0] ev_win, ev_csum;

  task automatic model_reset();
    m_last_win = 0; m_last_csum = 0; m_min = 16'hFFFF;
    m_tcp = 0; m_other = 0; m_zero = 0;
    m_in_pkt = 0; m_captured = 0; m_data.delete();
  endtask

  task automatic model_word(input logic [DW-1:0] d, input logic [CW-1:0] c);
    ev_cap = 0; ev_other = 0;
    if (!m_in_pkt) begin
      if (c == 0) begin
        m_in_pkt = 1; m_captured = 0;
        m_data.delete(); m_data.push_back(d);
      end
    end else if (c != 0) begin
      if (!m_captured) ev_other = 1;
      m_in_pkt = 0;
    end else begin
      m_data.push_back(d);
      if (m_data.size() == 7 && m_data[1][31:16] == 16'h0800 && m_data[1][15:8] == 8'h45 &&
          m_data[2][7:0] == 8'h06) begin
        ev_cap = 1; m_captured = 1;
        ev_win = m_data[6][63:48]; ev_csum = m_data[6][47:32];
      end
    end
  endtask

  always @(posedge clk) clr_edge <= stat_clr;

  logic [DW+CW-1:0] w;
  always @(negedge clk) begin
    if (!reset) begin
      model_reset();
      exp_q.delete();
    end else begin
      ev_cap = 0; ev_other = 0;
      if (out_wr) begin
        if (exp_q.size() == 0) chk("unexpected_out_wr", 64'd1, 64'd0);
        else begin
          w = exp_q.pop_front();
          chk("out_data", out_data, w[DW-1:0]);
          chk("out_ctrl", {56'd0, out_ctrl}, {56'd0, w[DW+CW-1:DW]});
          model_word(w[DW-1:0], w[DW+CW-1:DW]);
        end
      end
      if (clr_edge) begin
        m_min = 16'hFFFF; m_tcp = 0; m_other = 0; m_zero = 0;
      end else begin
        if (ev_cap) begin
          m_last_win = ev_win; m_last_csum = ev_csum; m_tcp++;
          if (ev_win < m_min) m_min = ev_win;
          if (ZW_EN && ev_win == 16'h0) m_zero++;
        end
        if (ev_other) m_other++;
      end
      chk("last_win", last_win, m_last_win);
      chk("last_csum", last_csum, m_last_csum);
      chk("min_win", min_win, m_min);
      chk("tcp_pkt_cnt", tcp_pkt_cnt, m_tcp);
      chk("other_pkt_cnt", other_pkt_cnt, m_other);
      chk("zero_win_cnt", zero_win_cnt, m_zero);
    end
  end

  // out_rdy pattern: 0 always ready, 1 toggling, 2 held low, 3 driven by the main sequence.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_rdy = 1'b1;
        1: out_rdy = ~out_rdy;
        2: out_rdy = 1'b0;
        default: ;
      endcase
    end
  end

  task automatic send_word(input logic [DW-1:0] d, input logic [CW-1:0] c);
    int n = 0;
    while (!in_rdy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_rdy) begin
      total++; bad++;
      $display("FAIL in_rdy_timeout: got 0 expected 1 at %0t", $time);
      return;
    end
    in_data = d; in_ctrl = c; in_wr = 1'b1;
    exp_q.push_back({c, d});
    @(posedge clk); #1;
    in_wr = 1'b0;
  endtask

  task automatic build_pkt(input int ndata, input logic [15:0] etype, input logic [7:0] ipv,
                           input logic [7:0] proto, input logic [15:0] win, input logic [15:0] csum);
    pkt_d.delete(); pkt_c.delete();
    pkt_d.push_back(64'hFF00_0000_0000_0040); pkt_c.push_back(8'hFF);
    for (int i = 1; i <= ndata; i++) begin
      case (i)
        1: pkt_d.push_back(64'h1111_0000_0000_0001);
        2: pkt_d.push_back({32'h2222_3333, etype, ipv, 8'h00});
        3: pkt_d.push_back({56'h3333_4444_5555_66, proto});
        7: pkt_d.push_back({win, csum, 32'h7777_0007});
        default: pkt_d.push_back({16'hD0D0, 16'(i), 32'h5555_AAAA});
      endcase
      pkt_c.push_back(8'h00);
    end
    pkt_d.push_back(64'hE0E0_E0E0_E0E0_E0E0); pkt_c.push_back(8'h40);
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_word(pkt_d[i], pkt_c[i]);
  endtask

  task automatic send_pkt();
    send_range(0, pkt_d.size() - 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_out_wr", {63'd0, out_wr}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_min_win", min_win, 64'hFFFF);
    chk("rst_tcp", tcp_pkt_cnt, 64'd0);
    chk("rst_in_rdy", {63'd0, in_rdy}, 64'd1);
    @(posedge clk); #1;

    build_pkt(7, 16'h0800, 8'h45, 8'h06, 16'h1000, 16'hBEEF);
    send_pkt(); wait_drain();
    chk("t1_last_win", last_win, 64'h1000);
    chk("t1_last_csum", last_csum, 64'hBEEF);
    chk("t1_tcp", tcp_pkt_cnt, 64'd1);

    build_pkt(6, 16'h86DD, 8'h60, 8'h06, 16'h0, 16'h0);
    send_pkt(); wait_drain();
    chk("t2_tcp", tcp_pkt_cnt, 64'd1);
    chk("t2_other", other_pkt_cnt, 64'd1);

    build_pkt(7, 16'h0800, 8'h45, 8'h06, 16'h0800, 16'h0001); send_pkt();
    build_pkt(7, 16'h0800, 8'h45, 8'h06, 16'h0200, 16'h0002); send_pkt();
    build_pkt(7, 16'h0800, 8'h45, 8'h06, 16'h0400, 16'h0003); send_pkt();
    wait_drain();
    chk("t3_min_win", min_win, 64'h0200);
    chk("t3_last_win", last_win, 64'h0400);
    chk("t3_tcp", tcp_pkt_cnt, 64'd4);

    rdy_mode = 1;
    build_pkt(8, 16'h0800, 8'h45, 8'h06, 16'h0777, 16'h1234);
    send_pkt(); wait_drain();
    rdy_mode = 0;
    chk("t4_last_win", last_win, 64'h0777);
    chk("t4_last_csum", last_csum, 64'h1234);
    chk("t4_tcp", tcp_pkt_cnt, 64'd5);

    build_pkt(8, 16'h0800, 8'h45, 8'h11, 16'h0001, 16'h0001); send_pkt();
    build_pkt(8, 16'h0800, 8'h46, 8'h06, 16'h0001, 16'h0001); send_pkt();
    build_pkt(5, 16'h0800, 8'h45, 8'h06, 16'h0001, 16'h0001); send_pkt();
    wait_drain();
    chk("t5_other", other_pkt_cnt, 64'd4);
    chk("t5_tcp", tcp_pkt_cnt, 64'd5);
    chk("t5_min_win", min_win, 64'h0200);

    pulse_clr();
    @(negedge clk);
    chk("t6_min_win", min_win, 64'hFFFF);
    chk("t6_tcp", tcp_pkt_cnt, 64'd0);
    chk("t6_other", other_pkt_cnt, 64'd0);
    chk("t6_last_win", last_win, 64'h0777);
    @(posedge clk); #1;

    build_pkt(7, 16'h0800, 8'h45, 8'h06, 16'h0000, 16'hABCD);
    send_pkt(); wait_drain();
    chk("t7_tcp", tcp_pkt_cnt, 64'd1);
    chk("t7_min_win", min_win, 64'h0000);
    chk("t7_zero", zero_win_cnt, ZW_EN ? 64'd1 : 64'd0);

    send_range(0, 6); wait_drain();
    rdy_mode = 3; out_rdy = 1'b0;
    send_range(7, 8);
    repeat (2) @(posedge clk);
    #1 out_rdy = 1'b1; stat_clr = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0; stat_clr = 1'b0;
    rdy_mode = 0;
    wait_drain();
    chk("t8_tcp", tcp_pkt_cnt, 64'd0);
    chk("t8_zero", zero_win_cnt, 64'd0);
    chk("t8_min_win", min_win, 64'hFFFF);
    chk("t8_other", other_pkt_cnt, 64'd0);

    rdy_mode = 2;
    build_pkt(7, 16'h0800, 8'h45, 8'h06, 16'h0555, 16'h0555);
    send_range(0, 2);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t9_out_wr", {63'd0, out_wr}, 64'd0);
    chk("t9_last_win", last_win, 64'd0);
    chk("t9_min_win", min_win, 64'hFFFF);
    @(posedge clk); #1;
    rdy_mode = 0;
    build_pkt(7, 16'h0800, 8'h45, 8'h06, 16'h0123, 16'h4567);
    send_pkt(); wait_drain();
    chk("t9_tcp", tcp_pkt_cnt, 64'd1);
    chk("t9_last_win2", last_win, 64'h0123);
    chk("t9_last_csum2", last_csum, 64'h4567);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/recwind_monitor.md
RECWIND_MONITOR -- requirements
Module: recwind_monitor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, datapath width.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, control width.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  in  DATA_WIDTH  upstream word.
REQ-006 SHALL have port in_ctrl  in  CTRL_WIDTH  upstream control; 0 = packet data word.
REQ-007 SHALL have port in_wr  in  1  upstream write strobe.
REQ-008 SHALL have port in_rdy  out  1  upstream may write.
REQ-009 SHALL have port out_data  out  DATA_WIDTH  downstream word, registered.
REQ-010 SHALL have port out_ctrl  out  CTRL_WIDTH  downstream control, registered.
REQ-011 SHALL have port out_wr  out  1  downstream write strobe, registered.
REQ-012 SHALL have port out_rdy  in  1  downstream may accept.
REQ-013 SHALL have port stat_clr  in  1  synchronous one-cycle pulse; clears statistics.
REQ-014 SHALL have port last_win  out  16  TCP receive window of last qualifying packet.
REQ-015 SHALL have port last_csum  out  16  TCP checksum of last qualifying packet.
REQ-016 SHALL have port min_win  out  16  smallest window captured since reset/clear.
REQ-017 SHALL have port tcp_pkt_cnt  out  32  qualifying packets captured.
REQ-018 SHALL have port other_pkt_cnt  out  32  non-qualifying packets forwarded.
REQ-019 SHALL have port zero_win_cnt  out  32  zero-window packets (see Configuration).

Function
REQ-020 SHALL forward every word unmodified, in order; block is a passive reader, never alters data.
REQ-021 SHALL buffer input in a 4-deep fall-through FIFO; in_rdy = !nearly_full (space >= 2 words).
REQ-022 SHALL pop FIFO when !empty && out_rdy; popped word appears on out_* next cycle with out_wr=1; out_wr=0 otherwise (latency 1 cycle).
REQ-023 SHALL implement FSM CTRL_HDR -> WORD2_ETH -> WORD3_IP -> WAIT_W7 -> CAPTURE -> PASS -> CTRL_HDR; only advances on a pop.
REQ-024 CTRL_HDR: forward words with in_ctrl!=0; first in_ctrl==0 word is data word D1, go WORD2_ETH.
REQ-025 WORD2_ETH: qualify if D2[31:16]==0x0800 and D2[15:8]==0x45 (IPv4, no options); else mark non-qualifying, go PASS.
REQ-026 WORD3_IP: qualify if D3[7:0]==0x06; else non-qualifying, go PASS.
REQ-027 WAIT_W7: 3-bit word counter; data word D7 captured: last_win<=D7[63:48], last_csum<=D7[47:32], min_win<=min(min_win,D7[63:48]), tcp_pkt_cnt+1.
REQ-028 PASS: forward until EOP (popped word with in_ctrl!=0 after D1), then CTRL_HDR.
REQ-029 Non-qualifying packet SHALL increment other_pkt_cnt exactly once, at its EOP.
REQ-030 EOP before D7 on a qualifying packet SHALL capture nothing, increment other_pkt_cnt, return to CTRL_HDR.
REQ-031 Counters SHALL wrap modulo 2^32.
REQ-032 stat_clr SHALL set min_win=0xFFFF, all counters 0; last_win/last_csum retained; clear wins over a same-cycle capture/increment (event dropped).
REQ-033 out_rdy low SHALL stall popping; FSM and outputs hold; no word lost or duplicated.

Reset
REQ-034 reset low SHALL asynchronously force: FSM CTRL_HDR, FIFO empty, out_wr=0, out_data=0, out_ctrl=0, last_win=0, last_csum=0, min_win=0xFFFF, all counters 0.
REQ-035 Reset mid-packet SHALL discard remaining buffered words; after release, next in_ctrl!=0 word starts a new packet.

Configuration
REQ-036 Macro RECWIND_MONITOR_ZERO_WIN_EN defined: on capture with D7[63:48]==0, zero_win_cnt+1 (cleared by stat_clr).
REQ-037 Macro undefined: zero_win_cnt constant 0, no counter logic; all other behaviour identical.

Verification
REQ-038 IPv4/TCP packet, 1 ctrl word, D7[63:48]=0x1000, D7[47:32]=0xBEEF -> identical output stream, last_win=0x1000, last_csum=0xBEEF, tcp_pkt_cnt=1.
REQ-039 Ethertype 0x86DD packet, 8 words -> forwarded unchanged, tcp_pkt_cnt=0, other_pkt_cnt=1.
REQ-040 Windows 0x0800, 0x0200, 0x0400 in three TCP packets -> min_win=0x0200, last_win=0x0400.
REQ-041 out_rdy toggled every other cycle during 10-word TCP packet -> output equals input, capture correct.
REQ-042 With ZERO_WIN_EN, window 0 packet then stat_clr same cycle as next capture -> zero_win_cnt=0, tcp_pkt_cnt=0, min_win=0xFFFF.
